// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bundle for the immediate-extension stage.
// The master drives immediates and consumes results; the slave is the stage.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_neg;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_neg
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_neg
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: zero/sign/upper/shifted-sign modes,
// registered output with a one-entry skid buffer behind it.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input logic              clk,
  input logic              rst_n,
  imm_extend_pipe_if.slave bus
);
  localparam int E = OUT_W - IN_W;

  logic [OUT_W-1:0] zx;
  logic [OUT_W-1:0] sx;
  logic [OUT_W-1:0] res;

  logic             m_valid_q, m_valid_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic             s_valid_q, s_valid_d;
  logic [OUT_W-1:0] s_data_q, s_data_d;

  logic in_xfer;
  logic m_drain;

  always_comb begin
    zx = {{E{1'b0}}, bus.in_imm};
    sx = {{E{bus.in_imm[IN_W-1]}}, bus.in_imm};
    res = zx;
    unique case (bus.in_mode)
      2'd0: res = zx;
      2'd1: res = sx;
      // Shifting the zero-extended value drops any bits above OUT_W
      2'd2: res = zx << E;
      2'd3: res = sx << SHAMT;
      default: res = zx;
    endcase
  end

  assign in_xfer = bus.in_valid && !s_valid_q;
  assign m_drain = !m_valid_q || bus.out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (m_drain) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (in_xfer) begin
        m_valid_d = 1'b1;
        m_data_d  = res;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      s_valid_d = 1'b1;
      s_data_d  = res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

  assign bus.in_ready  = !s_valid_q;
  assign bus.out_valid = m_valid_q;
  assign bus.out_data  = m_data_q;
  assign bus.out_neg   = m_data_q[OUT_W-1];
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed checks of imm_extend_pipe at two parameter sets
// plus a randomised handshake stream against a scoreboard.
module tb_imm_extend_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) b0 ();
  imm_extend_pipe_if #(.IN_W(12), .OUT_W(16)) b1 ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHAMT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  imm_extend_pipe #(.IN_W(12), .OUT_W(16), .SHAMT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [15:0] imm,
                      input logic [1:0] mode);
    b0.in_valid = v;
    b0.in_imm = imm;
    b0.in_mode = mode;
  endtask

  function automatic logic [31:0] model(input logic [15:0] imm,
                                        input logic [1:0] mode);
    logic [31:0] s;
    s = {{16{imm[15]}}, imm};
    case (mode)
      2'd0: return {16'h0000, imm};
      2'd1: return s;
      2'd2: return {imm, 16'h0000};
      default: return {s[29:0], 2'b00};
    endcase
  endfunction

  logic [31:0] q[$];
  logic [31:0] exp_v;
  logic [31:0] prev_data;
  logic prev_stall;
  int sent;
  int got;
  int cyc;

  initial begin
    drv0(1'b0, 16'h0, 2'd0);
    b0.out_ready = 1'b0;
    b1.in_valid = 1'b0;
    b1.in_imm = '0;
    b1.in_mode = 2'd0;
    b1.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_out_valid", 32'(b0.out_valid), 32'd0);
    chk("rst_out_data", b0.out_data, 32'h0);
    chk("rst_out_neg", 32'(b0.out_neg), 32'd0);
    chk("rst_in_ready", 32'(b0.in_ready), 32'd1);

    // Stream with out_ready high
    b0.out_ready = 1'b1;
    drv0(1'b1, 16'h8000, 2'd1);
    tick();
    chk("s1_valid", 32'(b0.out_valid), 32'd1);
    chk("s1_m1", b0.out_data, 32'hFFFF8000);
    drv0(1'b1, 16'h8000, 2'd0);
    tick();
    chk("s1_m0", b0.out_data, 32'h00008000);
    chk("s1_m0_neg", 32'(b0.out_neg), 32'd0);
    drv0(1'b1, 16'h1234, 2'd2);
    tick();
    chk("s1_m2", b0.out_data, 32'h12340000);
    drv0(1'b1, 16'hFFFF, 2'd3);
    tick();
    chk("s1_m3", b0.out_data, 32'hFFFFFFFC);
    chk("s1_m3_neg", 32'(b0.out_neg), 32'd1);
    chk("s1_m3_valid", 32'(b0.out_valid), 32'd1);
    drv0(1'b0, 16'h0, 2'd0);
    tick();
    chk("s1_idle", 32'(b0.out_valid), 32'd0);

    // Backpressure into the skid buffer
    b0.out_ready = 1'b0;
    drv0(1'b1, 16'h0001, 2'd1);
    tick();
    chk("bp_m", b0.out_data, 32'h00000001);
    chk("bp_rdy1", 32'(b0.in_ready), 32'd1);
    drv0(1'b1, 16'h7FFF, 2'd1);
    tick();
    chk("bp_rdy0", 32'(b0.in_ready), 32'd0);
    chk("bp_hold1", b0.out_data, 32'h00000001);
    drv0(1'b1, 16'h5555, 2'd1);
    tick();
    chk("bp_hold2", b0.out_data, 32'h00000001);
    chk("bp_rdy0b", 32'(b0.in_ready), 32'd0);
    drv0(1'b0, 16'h0, 2'd0);
    b0.out_ready = 1'b1;
    tick();
    chk("bp_second", b0.out_data, 32'h00007FFF);
    chk("bp_second_v", 32'(b0.out_valid), 32'd1);
    chk("bp_rdy_back", 32'(b0.in_ready), 32'd1);
    tick();
    chk("bp_empty", 32'(b0.out_valid), 32'd0);

    // Mode 3 truncation
    drv0(1'b1, 16'h4000, 2'd3);
    tick();
    chk("m3_4000", b0.out_data, 32'h00010000);
    drv0(1'b1, 16'h8001, 2'd3);
    tick();
    chk("m3_8001", b0.out_data, 32'hFFFE0004);
    drv0(1'b0, 16'h0, 2'd0);
    tick();

    // Reset with both registers full
    b0.out_ready = 1'b0;
    drv0(1'b1, 16'h0011, 2'd0);
    tick();
    drv0(1'b1, 16'h0022, 2'd0);
    tick();
    chk("rm_full", 32'(b0.in_ready), 32'd0);
    rst_n = 1'b0;
    b0.out_ready = 1'b1;
    drv0(1'b1, 16'h0033, 2'd0);
    tick();
    chk("rm_valid", 32'(b0.out_valid), 32'd0);
    chk("rm_data", b0.out_data, 32'h0);
    chk("rm_rdy", 32'(b0.in_ready), 32'd1);
    rst_n = 1'b1;
    drv0(1'b0, 16'h0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rm_no_stale", 32'(b0.out_valid), 32'd0);
    end

    // Narrow instance: IN_W=12, OUT_W=16, SHAMT=1
    b1.in_valid = 1'b1;
    b1.in_imm = 12'h800;
    b1.in_mode = 2'd1;
    tick();
    chk("p_m1", 32'(b1.out_data), 32'h0000F800);
    chk("p_m1_neg", 32'(b1.out_neg), 32'd1);
    b1.in_imm = 12'h0AB;
    b1.in_mode = 2'd2;
    tick();
    chk("p_m2", 32'(b1.out_data), 32'h00000AB0);
    b1.in_imm = 12'hFFF;
    b1.in_mode = 2'd3;
    tick();
    chk("p_m3", 32'(b1.out_data), 32'h0000FFFE);
    b1.in_valid = 1'b0;
    tick();
    chk("p_idle", 32'(b1.out_valid), 32'd0);

    // Random valid/ready stream, 1000 items
    sent = 0;
    got = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while ((got < 1000) && (cyc < 20000)) begin
      if (prev_stall) begin
        chk("rnd_hold_v", 32'(b0.out_valid), 32'd1);
        chk("rnd_hold_d", b0.out_data, prev_data);
      end
      if (sent < 1000) begin
        drv0(1'($urandom_range(0, 1)), 16'($urandom),
             2'($urandom_range(0, 3)));
      end else begin
        drv0(1'b0, 16'($urandom), 2'($urandom_range(0, 3)));
      end
      b0.out_ready = 1'($urandom_range(0, 1));
      if (b0.in_valid && b0.in_ready) begin
        q.push_back(model(b0.in_imm, b0.in_mode));
        sent++;
      end
      if (b0.out_valid && b0.out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_extra", 32'(q.size()), 32'd1);
        end else begin
          exp_v = q.pop_front();
          chk("rnd_data", b0.out_data, exp_v);
          chk("rnd_neg", 32'(b0.out_neg), 32'(exp_v[31]));
        end
        got++;
      end
      prev_stall = b0.out_valid && !b0.out_ready;
      prev_data = b0.out_data;
      tick();
      cyc++;
    end
    chk("rnd_count", 32'(got), 32'd1000);
    chk("rnd_left", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
